// File: rtl/inst_fetch_bridge.sv
// inst_fetch_bridge: one-entry instruction line buffer that turns CPU fetch misses into bus reads,
// completing each miss with the bus data, or with a NOP on a bus error or an ack timeout.
module inst_fetch_bridge #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rom_ce_i,
   input  logic [31:0] rom_addr_i,
   output logic [31:0] rom_data_o,
   output logic        stallreq_o,
   input  logic        invalidate_i,
   output logic        bus_req_o,
   output logic [31:0] bus_addr_o,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i,
   input  logic        bus_err_i,
   output logic        err_o,
   output logic        timeout_o
);
   typedef enum logic {IDLE, REQ} state_t;
   state_t      state;
   logic        valid;
   logic [29:0] tag;
   logic [31:0] data;
   logic [7:0]  wait_cnt;
   logic        hit;
   logic        expire;
   logic        unused_addr;
   assign unused_addr = ^rom_addr_i[1:0];
   assign hit        = rom_ce_i & valid & (tag == rom_addr_i[31:2]);
   assign rom_data_o = hit ? data : 32'h0;
   assign stallreq_o = rom_ce_i & ~hit;
   assign expire     = wait_cnt == 8'(TIMEOUT - 1);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         valid      <= 1'b0;
         tag        <= '0;
         data       <= '0;
         wait_cnt   <= '0;
         bus_req_o  <= 1'b0;
         bus_addr_o <= '0;
         err_o      <= 1'b0;
         timeout_o  <= 1'b0;
      end else begin
         err_o     <= 1'b0;
         timeout_o <= 1'b0;
         if (invalidate_i) valid <= 1'b0;
         if (state == IDLE) begin
            if (rom_ce_i && !hit) begin
               state      <= REQ;
               bus_req_o  <= 1'b1;
               bus_addr_o <= {rom_addr_i[31:2], 2'b00};
               wait_cnt   <= '0;
            end
         end else if (bus_ack_i || expire) begin
            // an ack wins over a coincident timeout; errors and timeouts fill a NOP
            state     <= IDLE;
            bus_req_o <= 1'b0;
            valid     <= ~invalidate_i;
            tag       <= bus_addr_o[31:2];
            data      <= (bus_ack_i && !bus_err_i) ? bus_rdata_i : 32'h0;
            err_o     <= bus_ack_i & bus_err_i;
            timeout_o <= ~bus_ack_i;
         end else begin
            wait_cnt <= wait_cnt + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_inst_fetch_bridge.sv
// tb_inst_fetch_bridge: directed checks of inst_fetch_bridge, with a default-timeout instance and a
// TIMEOUT=4 instance sharing all inputs.
module tb_inst_fetch_bridge;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rom_ce_i = 1'b0;
   logic [31:0] rom_addr_i = '0;
   logic        invalidate_i = 1'b0;
   logic        bus_ack_i = 1'b0;
   logic [31:0] bus_rdata_i = '0;
   logic        bus_err_i = 1'b0;
   logic [31:0] rom_data_o, bus_addr_o, data4, addr4;
   logic        stallreq_o, bus_req_o, err_o, timeout_o, stall4, req4, err4, to4;
   int          total = 0;
   int          bad = 0;

   inst_fetch_bridge dut (
      .clk(clk), .rst(rst), .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i), .rom_data_o(rom_data_o),
      .stallreq_o(stallreq_o), .invalidate_i(invalidate_i), .bus_req_o(bus_req_o),
      .bus_addr_o(bus_addr_o), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
      .bus_err_i(bus_err_i), .err_o(err_o), .timeout_o(timeout_o));

   inst_fetch_bridge #(.TIMEOUT(4)) dut4 (
      .clk(clk), .rst(rst), .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i), .rom_data_o(data4),
      .stallreq_o(stall4), .invalidate_i(invalidate_i), .bus_req_o(req4),
      .bus_addr_o(addr4), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
      .bus_err_i(bus_err_i), .err_o(err4), .timeout_o(to4));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      total++; if (bus_req_o !== 1'b0) begin bad++; $display("FAIL reset_req got %b want 0", bus_req_o); end
      total++; if (bus_addr_o !== 32'h0) begin bad++; $display("FAIL reset_addr got %h want 0", bus_addr_o); end
      total++; if ({err_o, timeout_o} !== 2'b00) begin bad++; $display("FAIL reset_pulses got %b want 00", {err_o, timeout_o}); end
      total++; if ({rom_data_o, stallreq_o} !== 33'h0) begin bad++; $display("FAIL reset_cpu got %h/%b want 0/0", rom_data_o, stallreq_o); end
      step();
      rst = 1'b0;
   endtask

   task automatic test_cold_fetch();
      rom_ce_i = 1'b1; rom_addr_i = 32'h0;
      @(negedge clk);
      total++; if ({stallreq_o, bus_req_o} !== 2'b10) begin bad++; $display("FAIL cold_t0 got stall/req %b want 10", {stallreq_o, bus_req_o}); end
      step();
      bus_ack_i = 1'b1; bus_rdata_i = 32'h34011100;
      @(negedge clk);
      total++; if ({stallreq_o, bus_req_o} !== 2'b11) begin bad++; $display("FAIL cold_t1 got stall/req %b want 11", {stallreq_o, bus_req_o}); end
      total++; if (bus_addr_o !== 32'h0) begin bad++; $display("FAIL cold_addr got %h want 0", bus_addr_o); end
      step();
      bus_ack_i = 1'b0;
      @(negedge clk);
      total++; if ({rom_data_o, stallreq_o, bus_req_o} !== {32'h34011100, 2'b00}) begin bad++; $display("FAIL cold_hit got %h/%b/%b want 34011100/0/0", rom_data_o, stallreq_o, bus_req_o); end
   endtask

   task automatic test_hit();
      step();
      rom_addr_i = 32'h2;
      @(negedge clk);
      total++; if ({rom_data_o, stallreq_o} !== {32'h34011100, 1'b0}) begin bad++; $display("FAIL hit_data got %h/%b want 34011100/0", rom_data_o, stallreq_o); end
      step();
      total++; if (bus_req_o !== 1'b0) begin bad++; $display("FAIL hit_noreq got %b want 0", bus_req_o); end
   endtask

   task automatic test_wait_states();
      rom_addr_i = 32'h13;
      step();
      for (int i = 1; i <= 5; i++) begin
         if (i == 5) begin bus_ack_i = 1'b1; bus_rdata_i = 32'hAABBCCDD; end
         @(negedge clk);
         total++; if ({bus_req_o, timeout_o} !== 2'b10) begin bad++; $display("FAIL wait_req cycle %0d got req/to %b want 10", i, {bus_req_o, timeout_o}); end
         total++; if (bus_addr_o !== 32'h10) begin bad++; $display("FAIL wait_addr cycle %0d got %h want 10", i, bus_addr_o); end
         step();
      end
      bus_ack_i = 1'b0;
      @(negedge clk);
      total++; if ({rom_data_o, bus_req_o, timeout_o} !== {32'hAABBCCDD, 2'b00}) begin bad++; $display("FAIL wait_done got %h/%b/%b want aabbccdd/0/0", rom_data_o, bus_req_o, timeout_o); end
   endtask

   task automatic test_error();
      step();
      rom_addr_i = 32'h8;
      step();
      bus_ack_i = 1'b1; bus_err_i = 1'b1; bus_rdata_i = 32'hDEADBEEF;
      step();
      bus_ack_i = 1'b0; bus_err_i = 1'b0;
      total++; if (err_o !== 1'b1) begin bad++; $display("FAIL err_pulse got %b want 1", err_o); end
      @(negedge clk);
      total++; if ({rom_data_o, stallreq_o} !== 33'h0) begin bad++; $display("FAIL err_nop got %h/%b want 0/0", rom_data_o, stallreq_o); end
      step();
      total++; if (err_o !== 1'b0) begin bad++; $display("FAIL err_single got %b want 0", err_o); end
   endtask

   task automatic test_timeout();
      int n = 0;
      do_reset();
      rom_ce_i = 1'b1; rom_addr_i = 32'h40;
      step();
      while (req4 && n < 20) begin n++; step(); end
      total++; if (n !== 4) begin bad++; $display("FAIL to_req_cycles got %0d want 4", n); end
      total++; if (to4 !== 1'b1) begin bad++; $display("FAIL to_pulse got %b want 1", to4); end
      @(negedge clk);
      total++; if ({data4, stall4} !== 33'h0) begin bad++; $display("FAIL to_nop got %h/%b want 0/0", data4, stall4); end
      step();
      total++; if (to4 !== 1'b0) begin bad++; $display("FAIL to_single got %b want 0", to4); end
   endtask

   task automatic test_ack_priority();
      do_reset();
      rom_ce_i = 1'b1; rom_addr_i = 32'h44;
      step(); step(); step(); step();
      bus_ack_i = 1'b1; bus_rdata_i = 32'h12345678;
      step();
      bus_ack_i = 1'b0;
      total++; if (to4 !== 1'b0) begin bad++; $display("FAIL prio_to got %b want 0", to4); end
      @(negedge clk);
      total++; if (data4 !== 32'h12345678) begin bad++; $display("FAIL prio_data got %h want 12345678", data4); end
   endtask

   task automatic test_reset_mid_req();
      do_reset();
      rom_ce_i = 1'b1; rom_addr_i = 32'h80;
      step();
      total++; if (bus_req_o !== 1'b1) begin bad++; $display("FAIL rmid_req got %b want 1", bus_req_o); end
      #2 rst = 1'b1;
      #1;
      total++; if (bus_req_o !== 1'b0) begin bad++; $display("FAIL rmid_async got %b want 0", bus_req_o); end
      step();
      rst = 1'b0; rom_ce_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'h55;
      step();
      bus_ack_i = 1'b0;
      total++; if (bus_req_o !== 1'b0) begin bad++; $display("FAIL idle_ack got %b want 0", bus_req_o); end
      rom_ce_i = 1'b1;
      @(negedge clk);
      total++; if (stallreq_o !== 1'b1) begin bad++; $display("FAIL idle_ack_nofill got %b want 1", stallreq_o); end
      step();
      bus_ack_i = 1'b1; bus_rdata_i = 32'h77; invalidate_i = 1'b1;
      step();
      bus_ack_i = 1'b0; invalidate_i = 1'b0;
      @(negedge clk);
      total++; if ({rom_data_o, stallreq_o} !== {32'h0, 1'b1}) begin bad++; $display("FAIL inv_fill got %h/%b want 0/1", rom_data_o, stallreq_o); end
   endtask

   task automatic test_ce_and_invalidate();
      step();
      bus_ack_i = 1'b1; bus_rdata_i = 32'h99;
      step();
      bus_ack_i = 1'b0;
      @(negedge clk);
      total++; if (rom_data_o !== 32'h99) begin bad++; $display("FAIL refill got %h want 99", rom_data_o); end
      step();
      rom_ce_i = 1'b0;
      @(negedge clk);
      total++; if ({rom_data_o, stallreq_o} !== 33'h0) begin bad++; $display("FAIL ce_off got %h/%b want 0/0", rom_data_o, stallreq_o); end
      step();
      total++; if (bus_req_o !== 1'b0) begin bad++; $display("FAIL ce_off_req got %b want 0", bus_req_o); end
      rom_ce_i = 1'b1; invalidate_i = 1'b1;
      @(negedge clk);
      total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL inv_same_cycle got %b want 0", stallreq_o); end
      step();
      invalidate_i = 1'b0;
      @(negedge clk);
      total++; if (stallreq_o !== 1'b1) begin bad++; $display("FAIL inv_miss got %b want 1", stallreq_o); end
   endtask

   initial begin
      test_reset();
      test_cold_fetch();
      test_hit();
      test_wait_states();
      test_error();
      test_timeout();
      test_ack_priority();
      test_reset_mid_req();
      test_ce_and_invalidate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
